data_pattern_gen: RTL

Parametrised test-data source feeding the UART transmit path. On each advance pulse (typically the 1-second tick) it emits the next word of a selectable pattern: up-count, down-count, PRBS (Galois LFSR) or fixed. The word is presented on a valid/ready holding register so a busy transmitter never loses or tears a word. Ticks that arrive while the transmitter is busy are counted as overruns.

---
 rtl/data_pattern_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/data_pattern_gen.sv
`timescale 1ns/1ps
// Test-data source for the UART transmit path: up/down/PRBS/fixed words
// handed over through a valid/ready holding register, dropped ticks counted.
module data_pattern_gen #(
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] LIMIT     = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(8'hB8),
    parameter int unsigned       OVR_W     = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              TICK,
    input  logic [1:0]        MODE,
    input  logic [DATA_W-1:0] SEED,
    input  logic              LOAD,
    output logic [DATA_W-1:0] DATA,
    output logic              VALID,
    input  logic              READY,
    output logic [OVR_W-1:0]  OVR_CNT
);

    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_PRBS  = 2'b10;
    localparam logic [1:0] MODE_FIXED = 2'b11;

    logic [DATA_W-1:0] gen_q, gen_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [OVR_W-1:0]  ovr_q, ovr_d;

    logic [DATA_W-1:0] gen_next_c;
    logic [DATA_W-1:0] seed_val_c;
    logic [DATA_W:0]   limit_diff_c;
    logic              above_c;
    logic              at_or_above_c;
    logic              fire_c;
    logic              free_c;
    logic              accept_c;
    logic              drop_c;

    // Limit compare via borrow, so a full-range LIMIT needs no special case.
    always_comb begin
        limit_diff_c  = {1'b0, LIMIT} - {1'b0, gen_q};
        above_c       = limit_diff_c[DATA_W];
        at_or_above_c = above_c | (limit_diff_c == '0);
    end

    // Next generator value for the currently selected pattern.
    always_comb begin
        gen_next_c = gen_q;
        case (MODE)
            MODE_UP: begin
                gen_next_c = at_or_above_c ? '0 : gen_q + DATA_W'(1);
            end
            MODE_DOWN: begin
                gen_next_c = ((gen_q == '0) || above_c) ? LIMIT : gen_q - DATA_W'(1);
            end
            MODE_PRBS: begin
                if (gen_q == '0) begin
                    gen_next_c = DATA_W'(1);
                end else begin
                    gen_next_c = (gen_q >> 1) ^ (gen_q[0] ? LFSR_POLY : '0);
                end
            end
            MODE_FIXED: begin
                gen_next_c = gen_q;
            end
            default: begin
                gen_next_c = gen_q;
            end
        endcase
    end

    // An all-zero PRBS seed would lock the LFSR, so it is loaded as 1.
    always_comb begin
        seed_val_c = SEED;
        if ((MODE == MODE_PRBS) && (SEED == '0)) begin
            seed_val_c = DATA_W'(1);
        end
    end

    always_comb begin
        fire_c   = TICK & ENABLE & ~LOAD;
        free_c   = ~valid_q | READY;
        accept_c = fire_c & free_c;
        drop_c   = fire_c & ~free_c;
    end

    // LOAD wins over everything; otherwise accept, consume or count a drop.
    always_comb begin
        gen_d   = gen_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (LOAD) begin
            gen_d   = seed_val_c;
            valid_d = 1'b0;
            ovr_d   = '0;
        end else if (accept_c) begin
            data_d  = gen_q;
            gen_d   = gen_next_c;
            valid_d = 1'b1;
        end else begin
            if (valid_q && READY) begin
                valid_d = 1'b0;
            end
            if (drop_c && (ovr_q != {OVR_W{1'b1}})) begin
                ovr_d = ovr_q + OVR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            gen_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            gen_q   <= gen_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign DATA    = data_q;
    assign VALID   = valid_q;
    assign OVR_CNT = ovr_q;

endmodule
